// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and the memory-access stage.
// MA has priority, but fetch is guaranteed a grant after STARVE_MAX consecutive MA grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              ma_req,
    input  logic              ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic              ma_done,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              stall_if,
    output logic              stall_ma,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              drop_q, drop_d;
    logic              store_q, store_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic              starve_hit;

    assign starve_hit = if_req && (starve_q == STARVE_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ma_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ma_rdata_q  <= ma_rdata_d;
        end
    end

    // mem_en and mem_we default low so the strobe lasts exactly the first WAIT cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        store_d     = store_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ma_rdata_d  = ma_rdata_q;

        case (state_q)
            IDLE: begin
                if (ma_req && !starve_hit) begin
                    owner_d     = OWN_MA;
                    state_d     = WAIT;
                    cnt_d       = LAT_LOAD;
                    drop_d      = 1'b0;
                    store_d     = ma_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ma_we;
                    mem_addr_d  = ma_addr;
                    mem_wdata_d = ma_wdata;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_req) begin
                    owner_d    = OWN_IF;
                    state_d    = WAIT;
                    cnt_d      = LAT_LOAD;
                    drop_d     = 1'b0;
                    store_d    = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = if_addr;
                    starve_d   = '0;
                end
            end
            WAIT: begin
                if (flush && (owner_q == OWN_IF)) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!store_q) begin
                        ma_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // No grant on this edge: requesters get a cycle to drop or change req.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_gnt    = (state_q == RESP) && (owner_q == OWN_IF) && !drop_q && !flush;
    assign ma_done   = (state_q == RESP) && (owner_q == OWN_MA);
    assign stall_if  = rst && if_req && !if_gnt;
    assign stall_ma  = rst && ma_req && !ma_done;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ma_rdata  = ma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses, a negedge monitor
// pops and compares them, and a small arbitration model checks every grant.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, flush, ma_req, ma_we;
    logic [ADDR_W-1:0] if_addr, ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic              if_gnt, ma_done, stall_if, stall_ma, mem_en, mem_we;
    logic [DATA_W-1:0] if_rdata, ma_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Memory device and the bench's own reference image of its contents.
    logic [DATA_W-1:0] mem_arr   [256];
    logic [DATA_W-1:0] model_mem [256];
    logic [DATA_W-1:0] last_load_m;

    logic [DATA_W-1:0] if_exp_q [$];
    logic [DATA_W-1:0] ma_exp_q [$];
    bit                grant_log [$];

    // Monitor-side state.
    bit                p_if, p_ma, p_ma_we;
    logic [ADDR_W-1:0] p_if_addr, p_ma_addr;
    logic [DATA_W-1:0] p_ma_wdata;
    int                starve_m = 0;
    int                if_en_cyc = 0, ma_en_cyc = 0;
    int                if_gnt_cyc = 0, ma_done_cyc = 0, if_gnt_cnt = 0, ma_done_cnt = 0;
    bit                exp_ma, act_ma;
    logic [DATA_W-1:0] popped;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .flush(flush),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_done(ma_done), .ma_rdata(ma_rdata),
        .stall_if(stall_if), .stall_ma(stall_ma),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    assign mem_rdata = mem_arr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
    end

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B1 + 32'h0BADF00D);
    endfunction

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fetch requester; with do_flush it kills its own access flush_dly cycles into WAIT.
    task automatic apply_if_txn(input logic [ADDR_W-1:0] addr, input bit do_flush,
                                input int flush_dly);
        bit done    = 1'b0;
        bit granted = 1'b0;
        int waited  = 0;
        if_req  = 1'b1;
        if_addr = addr;
        if (!do_flush) if_exp_q.push_back(model_mem[addr[9:2]]);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!do_flush && if_gnt) done = 1'b1;
            if (do_flush && !granted && mem_en && !mem_we && mem_addr == addr) granted = 1'b1;
            @(posedge clk); #1;
            if (do_flush && granted && !done) begin
                if (waited == flush_dly) begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                    done  = 1'b1;
                end else begin
                    waited++;
                end
            end
        end
        if (!done) check_output("if_txn_timeout", 32'd0, 32'd1);
        if_req = 1'b0;
    endtask

    task automatic apply_ma_txn(input bit we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata);
        bit done = 1'b0;
        ma_req   = 1'b1;
        ma_we    = we;
        ma_addr  = addr;
        ma_wdata = wdata;
        if (we) begin
            model_mem[addr[9:2]] = wdata;
        end else begin
            last_load_m = model_mem[addr[9:2]];
        end
        ma_exp_q.push_back(last_load_m);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ma_done) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check_output("ma_txn_timeout", 32'd0, 32'd1);
        ma_req = 1'b0;
        ma_we  = 1'b0;
    endtask

    // Fetch addresses live below 0x100, MA addresses at 0x100 and above.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_en) begin
                if (!p_if && !p_ma) check_output("grant_without_req", 32'd1, 32'd0);
                exp_ma = p_ma && !(p_if && starve_m == STARVE_MAX);
                act_ma = mem_we || (mem_addr >= 32'h100);
                grant_log.push_back(act_ma);
                check_output("grant_owner", 32'(act_ma), 32'(exp_ma));
                check_output("grant_addr", mem_addr, exp_ma ? p_ma_addr : p_if_addr);
                check_output("grant_we", 32'(mem_we), 32'(exp_ma && p_ma_we));
                if (exp_ma && p_ma_we) check_output("grant_wdata", mem_wdata, p_ma_wdata);
                if (exp_ma) begin
                    starve_m  = !p_if ? 0 : (starve_m == STARVE_MAX ? STARVE_MAX : starve_m + 1);
                    ma_en_cyc = cyc;
                end else begin
                    starve_m  = 0;
                    if_en_cyc = cyc;
                end
            end else begin
                check_output("mem_we_without_en", 32'(mem_we), 32'd0);
            end
            if (if_gnt) begin
                if_gnt_cnt++;
                if_gnt_cyc = cyc;
                if (if_exp_q.size() == 0) begin
                    check_output("if_gnt_unexpected", 32'd1, 32'd0);
                end else begin
                    popped = if_exp_q.pop_front();
                    check_output("if_rdata", if_rdata, popped);
                    check_output("if_latency", 32'(cyc - if_en_cyc), 32'(MEM_LAT));
                end
            end
            if (ma_done) begin
                ma_done_cnt++;
                ma_done_cyc = cyc;
                if (ma_exp_q.size() == 0) begin
                    check_output("ma_done_unexpected", 32'd1, 32'd0);
                end else begin
                    popped = ma_exp_q.pop_front();
                    check_output("ma_rdata", ma_rdata, popped);
                    check_output("ma_latency", 32'(cyc - ma_en_cyc), 32'(MEM_LAT));
                end
            end
            check_output("stall_if", 32'(stall_if), 32'(if_req && !if_gnt));
            check_output("stall_ma", 32'(stall_ma), 32'(ma_req && !ma_done));
        end
        p_if       = if_req;
        p_ma       = ma_req;
        p_ma_we    = ma_we;
        p_if_addr  = if_addr;
        p_ma_addr  = ma_addr;
        p_ma_wdata = ma_wdata;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, cnt_before, done_before;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i]   = init_word(i);
            model_mem[i] = init_word(i);
        end
        last_load_m = '0;
        rst = 1'b0; flush = 1'b0;
        if_req = 1'b1; ma_req = 1'b1; ma_we = 1'b1;
        if_addr = 32'h10; ma_addr = 32'h100; ma_wdata = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_mem_en", 32'(mem_en), 32'd0);
        check_output("rst_mem_we", 32'(mem_we), 32'd0);
        check_output("rst_stall_if", 32'(stall_if), 32'd0);
        check_output("rst_stall_ma", 32'(stall_ma), 32'd0);
        check_output("rst_strobes", 32'({if_gnt, ma_done}), 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_rdata", if_rdata | ma_rdata, 32'd0);
        if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] fetch only");
        c0 = cyc;
        apply_if_txn(32'h10, 1'b0, 0);
        check_output("if_only_gnt_cycle", 32'(if_gnt_cyc - c0), 32'(MEM_LAT + 1));

        $display("[TB] simultaneous fetch and load");
        c0 = cyc;
        fork
            apply_ma_txn(1'b0, 32'h200, 32'd0);
            apply_if_txn(32'h20, 1'b0, 0);
        join
        check_output("both_ma_done_cycle", 32'(ma_done_cyc - c0), 32'(MEM_LAT + 1));
        check_output("both_if_gnt_cycle", 32'(if_gnt_cyc - c0), 32'(2 * MEM_LAT + 3));

        $display("[TB] starvation limit");
        grant_log.delete();
        fork
            apply_if_txn(32'h30, 1'b0, 0);
            for (int k = 0; k < 6; k++) apply_ma_txn(1'b0, 32'h180 + 32'(4 * k), 32'd0);
        join
        check_output("starve_grant_count", 32'(grant_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++)
            check_output("starve_grant_order", 32'(grant_log[i]), 32'(i != STARVE_MAX));

        $display("[TB] flush during fetch");
        cnt_before = if_gnt_cnt;
        apply_if_txn(32'h08, 1'b1, 0);
        repeat (3) begin @(posedge clk); #1; end
        check_output("flush_no_gnt", 32'(if_gnt_cnt - cnt_before), 32'd0);
        apply_if_txn(32'h40, 1'b0, 0);
        check_output("post_flush_gnt", 32'(if_gnt_cnt - cnt_before), 32'd1);

        $display("[TB] store then load back");
        c0 = cyc;
        apply_ma_txn(1'b1, 32'h100, 32'h12345678);
        check_output("store_done_cycle", 32'(ma_done_cyc - c0), 32'(MEM_LAT + 1));
        apply_ma_txn(1'b0, 32'h100, 32'd0);

        $display("[TB] random traffic");
        fork
            for (int t = 0; t < 30; t++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                apply_if_txn(32'($urandom_range(0, 63)) << 2, $urandom_range(0, 3) == 0,
                             int'($urandom_range(0, MEM_LAT - 1)));
            end
            for (int t = 0; t < 30; t++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                apply_ma_txn(1'($urandom_range(0, 1)),
                             32'h100 + (32'($urandom_range(0, 191)) << 2), $urandom);
            end
        join
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] reset during access");
        if_req = 1'b1; if_addr = 32'h44;
        ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h104;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_output("midrst_mem_en", 32'(mem_en), 32'd0);
        check_output("midrst_mem_we", 32'(mem_we), 32'd0);
        check_output("midrst_stalls", 32'({stall_if, stall_ma}), 32'd0);
        check_output("midrst_strobes", 32'({if_gnt, ma_done}), 32'd0);
        if_exp_q.delete();
        ma_exp_q.delete();
        starve_m    = 0;
        last_load_m = '0;
        if_req = 1'b0; ma_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt_before  = if_gnt_cnt;
        done_before = ma_done_cnt;
        repeat (10) begin @(posedge clk); #1; end
        check_output("postrst_no_strobe", 32'(if_gnt_cnt - cnt_before + ma_done_cnt - done_before), 32'd0);
        apply_ma_txn(1'b0, 32'h104, 32'd0);
        apply_if_txn(32'h44, 1'b0, 0);
        check_output("postrst_strobes", 32'(if_gnt_cnt - cnt_before + ma_done_cnt - done_before), 32'd2);

        repeat (2) begin @(posedge clk); #1; end
        check_output("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
        check_output("ma_queue_drained", 32'(ma_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences a single-port unified memory shared by the fetch stage (instruction reads) and the memory-access stage (loads/stores) of the 5-stage pipeline. Arbitrates with MA priority plus an anti-starvation limit for fetch, and runs each access through a fixed-latency FSM. Generates per-stage stall signals and response strobes. Drops in-flight fetch responses on a branch flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en assertion to valid mem_rdata; legal range 1..15
STARVE_MAX, 4, consecutive MA grants allowed while if_req waits; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch read request; held until if_gnt or flush
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle strobe: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
flush  in  1  branch taken (from EX); kills in-flight fetch response
ma_req  in  1  MA access request; held until ma_done
ma_we  in  1  1=store, 0=load
ma_addr  in  ADDR_W  MA address
ma_wdata  in  DATA_W  store data
ma_done  out  1  one-cycle strobe: access complete
ma_rdata  out  DATA_W  load data
stall_if  out  1  fetch must hold
stall_ma  out  1  MA and older stages must hold
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address, held for whole access
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- rst low: state=IDLE immediately; all outputs 0; cnt, starve_cnt, owner, drop cleared. In-flight access abandoned, no strobe after release.
- States: IDLE, WAIT, RESP.
- IDLE, grant decision on edge:
  - ma_req && !(if_req && starve_cnt==STARVE_MAX): owner=MA.
  - else if if_req: owner=IF.
  - else stay IDLE.
- On grant, registered for the next cycle:
  - mem_en=1; mem_addr/mem_we/mem_wdata latched from owner (mem_we=0, mem_wdata unchanged for IF).
  - cnt=MEM_LAT-1; drop=0; state=WAIT.
- starve_cnt: on an MA grant with if_req high, starve_cnt+1, saturating at STARVE_MAX. On an IF grant, or an MA grant with if_req low, starve_cnt=0.
- WAIT:
  - mem_en=1 only in the first WAIT cycle, 0 afterward. mem_addr and mem_we held; mem_we clears when mem_en clears.
  - Each edge: if cnt==0, capture mem_rdata into the owner's rdata (loads and fetches only), state=RESP; else cnt-1.
  - Requester address/data changes during WAIT are ignored.
- flush: if high in any WAIT cycle with owner=IF, drop=1.
- RESP (one cycle):
  - if_gnt = (owner==IF) && !drop && !flush.
  - ma_done = (owner==MA).
  - Next edge: IDLE. No grant is made on that edge, so requesters get one cycle to deassert or change req.
- Stores: ma_done pulses; ma_rdata keeps its previous value.
- Rdata registers hold until the next capture for the same owner.
- Stalls (combinational from registered state):
  - stall_if = if_req && !if_gnt.
  - stall_ma = ma_req && !ma_done.
- Timing: a request sampled at edge E0 gives mem_en in cycle 1 and its strobe in cycle MEM_LAT+1. Back-to-back accesses therefore occupy MEM_LAT+2 cycles each.
- Simultaneous flush and IF grant in IDLE: the grant proceeds. Only flush during WAIT or RESP suppresses the response.

Test Plan:
- IF only, MEM_LAT=2, if_addr=0x10, mem returns 0xDEADBEEF -> mem_en=1 in cycle 1 with mem_addr=0x10, mem_we=0; if_gnt in cycle 3 with if_rdata=0xDEADBEEF; stall_if high in cycles 0-2.
- if_req and ma_req (load 0x200) both rise in cycle 0, starve_cnt=0 -> MA served first (ma_done cycle 3); IF mem_en in cycle 5, if_gnt in cycle 7.
- ma_req held for 6 back-to-back loads, if_req high throughout, STARVE_MAX=4 -> 4 MA grants, then an IF grant, then MA resumes; starve_cnt returns to 0 after the IF grant.
- IF access in flight, flush=1 in WAIT cycle 2 -> if_gnt never asserts; RESP/IDLE follow on schedule; the next if_req to 0x40 is serviced normally.
- Store: ma_we=1, ma_addr=0x100, ma_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and mem_wdata=0x12345678; ma_done in cycle 3; ma_rdata unchanged.
- rst driven low mid-WAIT -> mem_en, mem_we, stalls and strobes 0 immediately; after release with no requests, no if_gnt/ma_done ever appears; a new request completes normally.
